// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory boot loader.
//   state_e       - loader frame states
//   SYNC_BYTE     - frame start marker
//   LANES         - bytes per 32-bit instruction word
//   frame_busy()  - true while a frame is being received
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int unsigned LANES = 4;

  // A frame is in progress in every state except the resting ones.
  function automatic logic frame_busy(input state_e s);
    return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR));
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte-stream handshake plus instruction-memory write port.
//   in_data/in_valid/in_ready   - byte stream (transfer on valid && ready)
//   imem_we/imem_addr/imem_wdata - one-cycle word write strobe, byte address, data
// Modports: slave = loader side, master = stream source / memory side.
interface imem_boot_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport slave  (input  in_data, in_valid,
                  output in_ready, imem_we, imem_addr, imem_wdata);
  modport master (output in_data, in_valid,
                  input  in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from a byte stream.
//   clk, reset    - clock, asynchronous active-low reset
//   clear         - discard any partially assembled word
//   byte_valid    - byte_in is consumed this cycle
//   byte_in       - payload byte
//   word_ready    - pulse: this byte completes a word (combinational with byte_valid)
//   word          - completed word, valid together with word_ready
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_ready,
  output logic [31:0] word
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] asm_q,  asm_d;

  // Lane counter and word assembly register update.
  always_comb begin
    lane_d = lane_q;
    asm_d  = asm_q;
    if (clear) begin
      lane_d = 2'd0;
      asm_d  = 32'd0;
    end else if (byte_valid) begin
      asm_d[{lane_q, 3'b000} +: 8] = byte_in;
      lane_d = lane_q + 2'd1;
    end else begin
      lane_d = lane_q;
    end
  end

  // The completed word includes the current byte, so it is taken from asm_d.
  assign word_ready = byte_valid && !clear && (lane_q == 2'(LANES - 1));
  assign word       = asm_d;

  // Lane counter / assembly register state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q <= 2'd0;
      asm_q  <= 32'd0;
    end else begin
      lane_q <= lane_d;
      asm_q  <= asm_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a framed byte stream into instruction memory and
// holds the core in reset until a complete, length-checked image is written.
// Frame: A5, LEN lo, LEN hi, 4*LEN payload bytes (LE words), [checksum].
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   bus          - imem_boot_loader_if.slave (byte stream + imem write port)
//   cpu_reset_n  - core reset, released once the image is accepted
//   busy         - frame in progress
//   done         - image accepted (terminal until reset)
//   error        - frame rejected
// Build option: define IMEM_LOADER_CSUM_EN to require and check a trailing
// XOR checksum byte over LEN and payload bytes.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LEN_WIDTH   = 16
) (
  input  logic          clk,
  input  logic          reset,
  imem_boot_loader_if.slave bus,
  output logic          cpu_reset_n,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;

`ifdef IMEM_LOADER_CSUM_EN
  localparam state_e AFTER_DATA = ST_CSUM;
`else
  localparam state_e AFTER_DATA = ST_DONE;
`endif

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q,   len_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic                 ready_q, ready_d;
  logic                 we_q,    we_d;
  logic [31:0]          addr_q,  addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 cpu_rst_n_q, cpu_rst_n_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;
  logic                 error_q, error_d;

  logic                 accept_s;
  logic                 sync_s;
  logic                 pack_valid_s;
  logic                 pack_clear_s;
  logic                 word_ready_s;
  logic [31:0]          word_s;
  logic [LEN_WIDTH-1:0] len_next_s;
  logic                 last_word_s;

  assign accept_s     = bus.in_valid && ready_q;
  assign sync_s       = accept_s && (bus.in_data == SYNC_BYTE);
  assign pack_valid_s = accept_s && (state_q == ST_DATA);
  // A new frame starts from an empty word regardless of earlier history.
  assign pack_clear_s = sync_s && ((state_q == ST_IDLE) || (state_q == ST_ERROR));
  assign len_next_s   = LEN_WIDTH'({bus.in_data, len_q[7:0]});
  assign last_word_s  = ((32'(idx_q) + 32'd1) == 32'(len_q));

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear_s),
    .byte_valid (pack_valid_s),
    .byte_in    (bus.in_data),
    .word_ready (word_ready_s),
    .word       (word_s)
  );

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] xor_q, xor_d;

  // Running XOR over LEN and payload bytes; the sync byte is excluded.
  always_comb begin
    xor_d = xor_q;
    if (pack_clear_s) begin
      xor_d = 8'd0;
    end else if (accept_s && ((state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                              (state_q == ST_DATA))) begin
      xor_d = xor_q ^ bus.in_data;
    end else begin
      xor_d = xor_q;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xor_q <= 8'd0;
    end else begin
      xor_q <= xor_d;
    end
  end
`endif

  // Frame FSM next state, word index, length capture and write port.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (sync_s) begin
          state_d = ST_LEN0;
          idx_d   = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN0: begin
        if (accept_s) begin
          len_d[7:0] = bus.in_data;
          state_d    = ST_LEN1;
        end else begin
          state_d = ST_LEN0;
        end
      end
      ST_LEN1: begin
        if (accept_s) begin
          len_d = len_next_s;
          if (32'(len_next_s) > 32'(DEPTH_WORDS)) begin
            state_d = ST_ERROR;
          end else if (len_next_s == '0) begin
            state_d = AFTER_DATA;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_LEN1;
        end
      end
      ST_DATA: begin
        if (pack_valid_s && word_ready_s) begin
          we_d    = 1'b1;
          addr_d  = 32'({idx_q, 2'b00});
          wdata_d = word_s;
          idx_d   = idx_q + IDX_W'(1);
          if (last_word_s) begin
            state_d = AFTER_DATA;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      ST_CSUM: begin
        if (accept_s) begin
          state_d = (bus.in_data == xor_q) ? ST_DONE : ST_ERROR;
        end else begin
          state_d = ST_CSUM;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they move with it.
  always_comb begin
    ready_d     = (state_d != ST_DONE);
    busy_d      = frame_busy(state_d);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERROR);
    cpu_rst_n_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_reset_n    = cpu_rst_n_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed self-checking bench for imem_boot_loader.
// Works with or without IMEM_LOADER_CSUM_EN; checksum-specific scenarios are
// compiled only when the checksum byte is part of the frame.
module tb_imem_boot_loader;

  logic clk = 1'b0;
  logic reset;
  logic cpu_reset_n, busy, done, error;

  imem_boot_loader_if bus ();

  imem_boot_loader #(.DEPTH_WORDS(256), .LEN_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .cpu_reset_n (cpu_reset_n),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && t < 16) begin
      @(negedge clk);
      t++;
    end
    if (bus.in_ready !== 1'b1) begin
      total++;
      $display("FAIL send_timeout: in_ready got %b want 1", bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send_seq(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  // Frame A: one word 0x00500013, correct checksum 0x42.
  task automatic send_frame_a(input logic [7:0] csum);
    send_seq('{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00});
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(csum);
`else
    if (csum == 8'h00) $display("note: frame A sent without checksum");
`endif
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (2) @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); else passed++;
    total++; if (bus.imem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", bus.imem_we); else passed++;
    total++; if (bus.imem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", bus.imem_addr); else passed++;
    total++; if (bus.imem_wdata !== 32'h0) $display("FAIL rst_wdata: got %h want 0", bus.imem_wdata); else passed++;
    total++; if (cpu_reset_n !== 1'b0) $display("FAIL rst_cpu_reset_n: got %b want 0", cpu_reset_n); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
    total++; if (error !== 1'b0) $display("FAIL rst_error: got %b want 0", error); else passed++;
    reset = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    send_seq('{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h50});
    total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else passed++;
    total++; if (cpu_reset_n !== 1'b0) $display("FAIL single_cpu_held: got %b want 0", cpu_reset_n); else passed++;
    send_byte(8'h00);
`ifdef IMEM_LOADER_CSUM_EN
    total++; if (done !== 1'b0) $display("FAIL single_done_early: got %b want 0", done); else passed++;
    send_byte(8'h42);
`endif
    total++; if (done !== 1'b1) $display("FAIL single_done: got %b want 1", done); else passed++;
    total++; if (cpu_reset_n !== 1'b1) $display("FAIL single_cpu_rel: got %b want 1", cpu_reset_n); else passed++;
    settle();
    total++; if (wr_addr.size() != 1) $display("FAIL single_nwr: got %0d want 1", wr_addr.size()); else passed++;
    if (wr_addr.size() >= 1) begin
      total++; if (wr_addr[0] !== 32'h0) $display("FAIL single_addr: got %h want 0", wr_addr[0]); else passed++;
      total++; if (wr_data[0] !== 32'h00500013) $display("FAIL single_data: got %h want 00500013", wr_data[0]); else passed++;
    end
    total++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_seq('{8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
               8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C});
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'h0F);
`endif
    settle();
    total++; if (wr_addr.size() != 3) $display("FAIL b2b_nwr: got %0d want 3", wr_addr.size()); else passed++;
    if (wr_addr.size() == 3) begin
      total++; if (wr_addr[0] !== 32'h0 || wr_addr[1] !== 32'h4 || wr_addr[2] !== 32'h8)
        $display("FAIL b2b_addr: got %h %h %h want 0 4 8", wr_addr[0], wr_addr[1], wr_addr[2]); else passed++;
      total++; if (wr_data[0] !== 32'h04030201 || wr_data[1] !== 32'h08070605 || wr_data[2] !== 32'h0C0B0A09)
        $display("FAIL b2b_data: got %h %h %h", wr_data[0], wr_data[1], wr_data[2]); else passed++;
      total++; if (wr_cyc[1] - wr_cyc[0] != 4 || wr_cyc[2] - wr_cyc[1] != 4)
        $display("FAIL b2b_spacing: got %0d %0d want 4 4", wr_cyc[1] - wr_cyc[0], wr_cyc[2] - wr_cyc[1]); else passed++;
    end
    total++; if (bus.imem_addr !== 32'h8) $display("FAIL b2b_addr_hold: got %h want 8", bus.imem_addr); else passed++;
    total++; if (done !== 1'b1) $display("FAIL b2b_done: got %b want 1", done); else passed++;
  endtask

  task automatic test_garbage();
    do_reset();
    send_seq('{8'h00, 8'hFF, 8'h12});
    total++; if (busy !== 1'b0) $display("FAIL garb_busy: got %b want 0", busy); else passed++;
    send_frame_a(8'h42);
    settle();
    total++; if (wr_addr.size() != 1) $display("FAIL garb_nwr: got %0d want 1", wr_addr.size()); else passed++;
    if (wr_addr.size() >= 1) begin
      total++; if (wr_data[0] !== 32'h00500013) $display("FAIL garb_data: got %h want 00500013", wr_data[0]); else passed++;
    end
    total++; if (done !== 1'b1) $display("FAIL garb_done: got %b want 1", done); else passed++;
  endtask

`ifdef IMEM_LOADER_CSUM_EN
  task automatic test_bad_csum();
    do_reset();
    send_frame_a(8'h43);
    total++; if (error !== 1'b1) $display("FAIL csum_error: got %b want 1", error); else passed++;
    total++; if (cpu_reset_n !== 1'b0) $display("FAIL csum_cpu: got %b want 0", cpu_reset_n); else passed++;
    total++; if (done !== 1'b0) $display("FAIL csum_done: got %b want 0", done); else passed++;
    send_frame_a(8'h42);
    settle();
    total++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL csum_recover: got done=%b error=%b want 1 0", done, error); else passed++;
    total++; if (wr_addr.size() != 2) $display("FAIL csum_nwr: got %0d want 2", wr_addr.size()); else passed++;
    if (wr_addr.size() == 2) begin
      total++; if (wr_addr[1] !== 32'h0) $display("FAIL csum_addr: got %h want 0", wr_addr[1]); else passed++;
    end
  endtask
`endif

  task automatic test_overlength();
    do_reset();
    send_seq('{8'hA5, 8'h01, 8'h01});
    total++; if (error !== 1'b1) $display("FAIL ovl_error: got %b want 1", error); else passed++;
    total++; if (busy !== 1'b0 || cpu_reset_n !== 1'b0) $display("FAIL ovl_status: got busy=%b cpu=%b want 0 0", busy, cpu_reset_n); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL ovl_ready: got %b want 1", bus.in_ready); else passed++;
    send_byte(8'h00);
    total++; if (error !== 1'b1) $display("FAIL ovl_discard: got %b want 1", error); else passed++;
    send_byte(8'hA5);
    total++; if (error !== 1'b0 || busy !== 1'b1) $display("FAIL ovl_resync: got error=%b busy=%b want 0 1", error, busy); else passed++;
    settle();
    total++; if (wr_addr.size() != 0) $display("FAIL ovl_nwr: got %0d want 0", wr_addr.size()); else passed++;
    send_seq('{8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00});
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'h42);
`endif
    total++; if (done !== 1'b1) $display("FAIL ovl_reload: got %b want 1", done); else passed++;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send_seq('{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00});
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++;
    @(negedge clk);
    reset = 1'b1;
    settle();
    total++; if (wr_addr.size() != 0) $display("FAIL mid_nwr: got %0d want 0", wr_addr.size()); else passed++;
    // Strobe in flight when reset hits must vanish.
    send_seq('{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00});
    reset = 1'b0;
    #1;
    total++; if (bus.imem_we !== 1'b0) $display("FAIL mid_drop_we: got %b want 0", bus.imem_we); else passed++;
    @(negedge clk);
    reset = 1'b1;
    settle();
    total++; if (wr_addr.size() != 0) $display("FAIL mid_drop_nwr: got %0d want 0", wr_addr.size()); else passed++;
    send_frame_a(8'h42);
    settle();
    total++; if (wr_addr.size() != 1) $display("FAIL mid_reload_nwr: got %0d want 1", wr_addr.size()); else passed++;
    if (wr_addr.size() >= 1) begin
      total++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h00500013)
        $display("FAIL mid_reload_word: got %h@%h want 00500013@0", wr_data[0], wr_addr[0]); else passed++;
    end
    total++; if (bus.in_ready !== 1'b0) $display("FAIL done_ready: got %b want 0", bus.in_ready); else passed++;
    @(negedge clk);
    bus.in_data = 8'hA5;
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    settle();
    total++; if (wr_addr.size() != 1 || done !== 1'b1) $display("FAIL done_ignore: got nwr=%0d done=%b want 1 1", wr_addr.size(), done); else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++; if (cpu_reset_n !== 1'b0 || done !== 1'b0) $display("FAIL async_rst: got cpu=%b done=%b want 0 0", cpu_reset_n, done); else passed++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_garbage();
`ifdef IMEM_LOADER_CSUM_EN
    test_bad_csum();
`endif
    test_overlength();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
